// File: rtl/dynamic_scanner_pkg.sv
// Shared types and constants for the multiplexed display scanner.
package dynamic_scanner_pkg;

  localparam int unsigned BRIGHT_W = 4;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_e;

endpackage

// File: rtl/dynamic_scanner_scan_prescaler.sv
// Divides the clock into a one-cycle scan tick every PRESCALE clocks.
module scan_prescaler #(
  parameter int unsigned PRESCALE = 1000
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  localparam int unsigned CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CNT_W'(PRESCALE - 1));

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (tick) cnt_d = '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/dynamic_scanner.sv
// Time-multiplexed digit scanner with per-slot blanking and optional PWM dimming.
// Optional feature: define DYN_SCAN_PWM_EN to enable brightness PWM gating.
module dynamic_scanner
  import dynamic_scanner_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned CODE_W      = 4,
  parameter int unsigned PRESCALE    = 1000,
  parameter int unsigned SLOT_TICKS  = 4,
  parameter int unsigned BLANK_TICKS = 1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_DIGITS*CODE_W-1:0] codes,
  input  logic [NUM_DIGITS-1:0]        digitEnable,
  input  logic [BRIGHT_W-1:0]          brightness,
  output logic [NUM_DIGITS-1:0]        digit,
  output logic [CODE_W-1:0]            dynamicDigit,
  output logic [$clog2(NUM_DIGITS)-1:0] scanIndex,
  output logic                         frameStart
);

  localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
  localparam int unsigned SC_W  = $clog2(SLOT_TICKS);

  logic              tick;
  logic              wrap;
  logic              in_blank;
  logic              gate;
  logic [SC_W-1:0]   sc_q, sc_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  scan_state_e       state_q, state_d;
  logic [NUM_DIGITS-1:0] digit_q, digit_d;
  logic [CODE_W-1:0] dd_q, dd_d;
  logic              fs_q, fs_d;
  logic              loaded_q;

  scan_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clock(clock),
    .reset(reset),
    .tick (tick)
  );

  assign wrap = tick && (sc_q == SC_W'(SLOT_TICKS - 1));

  // Slot tick counter and scan index advance
  always_comb begin
    sc_d  = sc_q;
    idx_d = idx_q;
    if (tick) begin
      if (wrap) begin
        sc_d  = '0;
        idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
      end else begin
        sc_d = sc_q + SC_W'(1);
      end
    end
  end

  if (BLANK_TICKS > 0) begin : g_blank
    assign in_blank = (sc_d < SC_W'(BLANK_TICKS));
  end else begin : g_no_blank
    assign in_blank = 1'b0;
  end

`ifdef DYN_SCAN_PWM_EN
  logic [BRIGHT_W-1:0] pwm_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) pwm_q <= '0;
    else       pwm_q <= pwm_q + BRIGHT_W'(1);
  end

  assign gate = (pwm_q < brightness);
`else
  logic unused_brightness;
  assign unused_brightness = ^brightness;
  assign gate = 1'b1;
`endif

  // FSM: state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= ST_BLANK;
    else       state_q <= state_d;
  end

  // FSM: next state follows the slot tick position so it lines up with the slot counters
  always_comb begin
    state_d = state_q;
    if (in_blank) state_d = ST_BLANK;
    else          state_d = ST_SHOW;
  end

  // FSM: outputs, computed from the upcoming state so the registered digit aligns with the slot
  always_comb begin
    digit_d = '0;
    dd_d    = dd_q;
    fs_d    = wrap && (idx_q == IDX_W'(NUM_DIGITS - 1));
    if ((state_d == ST_SHOW) && digitEnable[idx_d] && gate) digit_d[idx_d] = 1'b1;
    if (wrap || !loaded_q) dd_d = codes[idx_d*CODE_W +: CODE_W];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sc_q     <= '0;
      idx_q    <= '0;
      digit_q  <= '0;
      dd_q     <= '0;
      fs_q     <= 1'b0;
      loaded_q <= 1'b0;
    end else begin
      sc_q     <= sc_d;
      idx_q    <= idx_d;
      digit_q  <= digit_d;
      dd_q     <= dd_d;
      fs_q     <= fs_d;
      loaded_q <= 1'b1;
    end
  end

  assign digit        = digit_q;
  assign dynamicDigit = dd_q;
  assign scanIndex    = idx_q;
  assign frameStart   = fs_q;

endmodule

// File: tb/tb_dynamic_scanner.sv
// Directed bench: scanner A (PRESCALE=2, BLANK_TICKS=1) and scanner B (PRESCALE=1, BLANK_TICKS=0).
module tb_dynamic_scanner;

  logic       clk;
  logic       rst;
  logic [8:0] codes_a;
  logic [2:0] en_a;
  logic [2:0] en_b;
  logic [3:0] bright;
  logic [2:0] dig_a, dig_b;
  logic [2:0] dd_a, dd_b;
  logic [1:0] idx_a, idx_b;
  logic       fs_a, fs_b;
  logic [2:0] cur_dd [3];

  int checks = 0;
  int errors = 0;

  dynamic_scanner #(
    .NUM_DIGITS(3), .CODE_W(3), .PRESCALE(2), .SLOT_TICKS(4), .BLANK_TICKS(1)
  ) dut_a (
    .clock(clk), .reset(rst), .codes(codes_a), .digitEnable(en_a), .brightness(bright),
    .digit(dig_a), .dynamicDigit(dd_a), .scanIndex(idx_a), .frameStart(fs_a)
  );

  dynamic_scanner #(
    .NUM_DIGITS(3), .CODE_W(3), .PRESCALE(1), .SLOT_TICKS(4), .BLANK_TICKS(0)
  ) dut_b (
    .clock(clk), .reset(rst), .codes(codes_a), .digitEnable(en_b), .brightness(bright),
    .digit(dig_b), .dynamicDigit(dd_b), .scanIndex(idx_b), .frameStart(fs_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  // PWM counter equals (k-1) mod 16 on the edge that produces sample k
  function automatic bit gate_open(input int k);
`ifdef DYN_SCAN_PWM_EN
    return (((k - 1) % 16) < int'(bright));
`else
    return (k >= 0);
`endif
  endfunction

  task automatic chk_reset(input int k);
    chk("rst_digit_a", k, 32'(dig_a), 32'd0);
    chk("rst_dd_a",    k, 32'(dd_a),  32'd0);
    chk("rst_idx_a",   k, 32'(idx_a), 32'd0);
    chk("rst_fs_a",    k, 32'(fs_a),  32'd0);
    chk("rst_digit_b", k, 32'(dig_b), 32'd0);
  endtask

  // Sample k is taken on the falling edge after the k-th rising edge since reset release
  task automatic step(input int k);
    int s, p, bs;
    logic [2:0] ed, eb;
    @(posedge clk);
    @(negedge clk);
    s  = (k / 8) % 3;
    p  = k % 8;
    bs = (k / 4) % 3;
    ed = (p >= 2 && en_a[s] && gate_open(k)) ? 3'(1 << s) : 3'b000;
    eb = gate_open(k) ? 3'(1 << bs) : 3'b000;
    chk("digit_a", k, 32'(dig_a), 32'(ed));
    chk("dd_a",    k, 32'(dd_a),  32'(cur_dd[s]));
    chk("idx_a",   k, 32'(idx_a), 32'(s));
    chk("fs_a",    k, 32'(fs_a),  32'((k % 24) == 0));
    chk("digit_b", k, 32'(dig_b), 32'(eb));
  endtask

  initial begin
    rst     = 1'b1;
    codes_a = {3'd5, 3'd3, 3'd6};
    en_a    = 3'b111;
    en_b    = 3'b111;
`ifdef DYN_SCAN_PWM_EN
    bright  = 4'd4;
`else
    bright  = 4'd0;
`endif
    cur_dd[0] = 3'd6;
    cur_dd[1] = 3'd3;
    cur_dd[2] = 3'd5;

    repeat (3) @(negedge clk);
    chk_reset(0);
    rst = 1'b0;

    for (int k = 1; k < 48; k++) step(k);

    en_a = 3'b101;
    for (int k = 48; k < 72; k++) step(k);
    en_a = 3'b111;

`ifdef DYN_SCAN_PWM_EN
    bright = 4'd0;
`endif
    for (int k = 72; k < 76; k++) step(k);
    codes_a[2:0] = 3'd2;
    for (int k = 76; k < 96; k++) step(k);
    cur_dd[0] = 3'd2;
`ifdef DYN_SCAN_PWM_EN
    bright = 4'd4;
`endif
    for (int k = 96; k < 131; k++) step(k);

    rst = 1'b1;
    #1;
    chk_reset(-1);
    @(posedge clk);
    @(negedge clk);
    chk_reset(-2);
    rst = 1'b0;
    for (int k = 1; k < 48; k++) step(k);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
